deal_sequencer: RTL and testbench
=================================

Name: deal_sequencer

Overview:
- Clock-domain-1 front end for the card-game CDC datapath.
- Takes card requests from two player sources over req/ack handshakes and enforces turn order: player 1 gets cards 1-5 of a game, player 2 gets cards 6-10.
- Tracks deck and per-rank availability, and rejects illegal or exhausted cards.
- Issues single-cycle in_valid1/in_valid2 pulses with user1/user2 values, spaced so the downstream toggle synchronizers into clk2 never miss a pulse.

Parameters:
- GAP, 4: minimum idle clk1 cycles after each issued pulse; legal range 1-15.
- CARDS_PER_HAND, 5: cards dealt to each player per game.
- DECK_SIZE, 52: deck_left reload value.
- RESHUFFLE_AT, 2: deck_left value that triggers a reshuffle.

Ports:
- clk1  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a game; honoured only in IDLE
- p1_req  in  1  player 1 request; held until p1_ack
- p1_card  in  4  player 1 card value; stable while p1_req
- p1_ack  out  1  combinational accept of p1_card
- p2_req  in  1  player 2 request
- p2_card  in  4  player 2 card value
- p2_ack  out  1  combinational accept of p2_card
- in_valid1  out  1  registered one-cycle pulse, player 1 card issued
- user1  out  4  registered player 1 card; updates only on issue
- in_valid2  out  1  registered one-cycle pulse, player 2 card issued
- user2  out  4  registered player 2 card
- err_card  out  1  registered one-cycle pulse, request rejected
- turn  out  2  0 idle, 1 player 1, 2 player 2
- busy  out  1  state != IDLE
- deck_left  out  6  cards remaining in deck
- game_cnt  out  8  completed games, wraps 255->0

Behaviour:
- Reset values: all outputs 0, except deck_left=DECK_SIZE; every rank count=4; gap_cnt=0; state IDLE.
- FSM states: IDLE, P1, P2.
  - IDLE --start--> P1, hand_cnt=0.
  - P1 --hand_cnt reaches CARDS_PER_HAND--> P2, hand_cnt cleared.
  - P2 --hand_cnt reaches CARDS_PER_HAND--> IDLE; game_cnt increments on that same edge.
  - start outside IDLE is ignored.
- Accept condition: pX_ack = (state==PX) & pX_req & (gap_cnt==0) & !reload.
  - Requests from the player not on turn get no ack and stay pending.
- Valid card is 1..13 with rank count > 0. On acceptance of a valid card, next edge:
  - in_valid_X=1, user_X=card;
  - rank count decremented, deck_left decremented;
  - hand_cnt incremented; gap_cnt loaded with GAP.
- Invalid card is 0, 14, 15, or a rank with count 0. On acceptance, next edge:
  - err_card=1 only;
  - no pulse, no count change, no gap load.
- Latency: one cycle from ack to in_valid. Minimum pulse spacing is GAP+1 cycles.
- gap_cnt decrements by 1 per cycle while nonzero, in every state.
- reload = (deck_left==RESHUFFLE_AT). When reload is high, the next edge sets deck_left=DECK_SIZE and all rank counts to 4.
  - Reload has priority; no accept occurs in that cycle.
  - hand_cnt and state are unaffected, so a reshuffle can fall mid-game.
- Rank counts are 3-bit, range 0-4, and never underflow because exhausted ranks are rejected.
- user1/user2 hold their last issued value between pulses.
- in_valid1 and in_valid2 are never high in the same cycle.
- Asynchronous reset mid-game returns everything to reset values immediately. There is no partial-game recovery.

Decomposition:
- Shared package deal_pkg:
  - state enum {IDLE,P1,P2};
  - constants MAX_RANK=13, RANK_COPIES=4, DECK_SIZE_DEF=52;
  - 4-bit card_t typedef.
- One sub-module, rank_tracker: 13 x 3-bit counters with ports decrement-on-rank, reload, and an available flag for a queried rank.
- The FSM, gap counter, deck counter and output registers stay in deal_sequencer.

Test Plan:
- Nominal game:
  - Stimulus: start; p1 cards 2,3,4,5,6 with p1_req held continuously; then p2 cards 7,8,9,10,1.
  - Response: 10 pulses spaced exactly 5 cycles apart (GAP=4); turn goes 1 then 2 then 0; game_cnt=1; deck_left=42.
- Wrong-turn request:
  - Stimulus: p2_req with card 9 while turn=1.
  - Response: no p2_ack until turn=2; the first player-2 pulse carries user2=9.
- Illegal and exhausted cards:
  - Stimulus: card 0 in P1, then card 14, then the 5th card of rank 7 in one deck.
  - Response: each gives an ack plus an err_card pulse; no in_valid; deck_left and hand_cnt unchanged.
- Reshuffle:
  - Stimulus: deal 50 valid cards across 5 games.
  - Response: deck_left reaches 2, then 52 on the next cycle; no ack in that cycle; rank 7 is accepted again afterwards.
- Spacing under pressure:
  - Stimulus: GAP=1 with p1_req held high.
  - Response: pulses every 2nd cycle; in_valid1 and in_valid2 are never simultaneous.
- Reset mid-game:
  - Stimulus: assert rst_n low after the 3rd card.
  - Response: all outputs 0, deck_left=52, state IDLE; a subsequent start runs a normal game.

Source files
------------

// File: rtl/deal_pkg.sv
// rtl/deal_pkg.sv - shared types and constants for the clk1 deal front end
package deal_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    P1   = 2'd1,
    P2   = 2'd2
  } state_t;

  localparam int MAX_RANK      = 13;
  localparam int RANK_COPIES   = 4;
  localparam int DECK_SIZE_DEF = 52;

  typedef logic [3:0] card_t;

endpackage

// File: rtl/deal_sequencer_rank_tracker.sv
// rtl/deal_sequencer_rank_tracker.sv - per-rank copy counters with availability lookup
module rank_tracker
  import deal_pkg::*;
(
  input  logic       clk1,
  input  logic       rst_n,
  input  logic       dec_en,
  input  logic [3:0] dec_rank,
  input  logic       reload,
  input  logic [3:0] query_rank,
  output logic       avail
);

  logic [2:0] cnt_q [MAX_RANK];
  logic [2:0] cnt_d [MAX_RANK];

  // Slot i holds rank i+1; ranks 0, 14 and 15 match no slot and read unavailable.
  always_comb begin
    avail = 1'b0;
    for (int i = 0; i < MAX_RANK; i++) begin
      cnt_d[i] = cnt_q[i];
      if (reload) begin
        cnt_d[i] = 3'(RANK_COPIES);
      end else if (dec_en && (dec_rank == 4'(i + 1))) begin
        cnt_d[i] = cnt_q[i] - 3'd1;
      end
      if ((query_rank == 4'(i + 1)) && (cnt_q[i] != 3'd0)) begin
        avail = 1'b1;
      end
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_RANK; i++) begin
        cnt_q[i] <= 3'(RANK_COPIES);
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/deal_sequencer.sv
// rtl/deal_sequencer.sv - turn-ordered card dealer issuing spaced pulses toward clk2
module deal_sequencer
  import deal_pkg::*;
#(
  parameter int unsigned GAP            = 4,
  parameter int unsigned CARDS_PER_HAND = 5,
  parameter int unsigned DECK_SIZE      = DECK_SIZE_DEF,
  parameter int unsigned RESHUFFLE_AT   = 2
) (
  input  logic       clk1,
  input  logic       rst_n,
  input  logic       start,
  input  logic       p1_req,
  input  logic [3:0] p1_card,
  output logic       p1_ack,
  input  logic       p2_req,
  input  logic [3:0] p2_card,
  output logic       p2_ack,
  output logic       in_valid1,
  output logic [3:0] user1,
  output logic       in_valid2,
  output logic [3:0] user2,
  output logic       err_card,
  output logic [1:0] turn,
  output logic       busy,
  output logic [5:0] deck_left,
  output logic [7:0] game_cnt
);

  state_t     state_q, state_d;
  logic [3:0] hand_q, hand_d;
  logic [3:0] gap_q, gap_d;
  logic [5:0] deck_q, deck_d;
  logic [7:0] game_q, game_d;
  logic       in_valid1_q, in_valid1_d, in_valid2_q, in_valid2_d;
  logic [3:0] user1_q, user1_d, user2_q, user2_d;
  logic       err_q, err_d;

  logic  reload, accept, card_ok, issue, hand_done;
  card_t card;

  assign reload = (deck_q == 6'(RESHUFFLE_AT));
  assign p1_ack = (state_q == P1) & p1_req & (gap_q == 4'd0) & ~reload;
  assign p2_ack = (state_q == P2) & p2_req & (gap_q == 4'd0) & ~reload;
  assign accept = p1_ack | p2_ack;
  assign card   = p1_ack ? p1_card : p2_card;
  assign issue  = accept & card_ok;
  assign hand_done = ((hand_q + 4'd1) == 4'(CARDS_PER_HAND));

  rank_tracker u_rank_tracker (
    .clk1       (clk1),
    .rst_n      (rst_n),
    .dec_en     (issue),
    .dec_rank   (card),
    .reload     (reload),
    .query_rank (card),
    .avail      (card_ok)
  );

  always_comb begin
    state_d     = state_q;
    hand_d      = hand_q;
    deck_d      = deck_q;
    game_d      = game_q;
    user1_d     = user1_q;
    user2_d     = user2_q;
    in_valid1_d = 1'b0;
    in_valid2_d = 1'b0;
    err_d       = 1'b0;
    gap_d       = (gap_q != 4'd0) ? (gap_q - 4'd1) : 4'd0;

    // Reload masks both acks, so it never coincides with an issue or a reject.
    if (reload) begin
      deck_d = 6'(DECK_SIZE);
    end else if (issue) begin
      deck_d      = deck_q - 6'd1;
      hand_d      = hand_q + 4'd1;
      gap_d       = 4'(GAP);
      in_valid1_d = p1_ack;
      in_valid2_d = p2_ack;
      if (p1_ack) user1_d = card;
      else        user2_d = card;
      if (hand_done) begin
        hand_d  = 4'd0;
        state_d = (state_q == P1) ? P2 : IDLE;
        if (state_q == P2) game_d = game_q + 8'd1;
      end
    end else if (accept) begin
      err_d = 1'b1;
    end

    if ((state_q == IDLE) && start) begin
      state_d = P1;
      hand_d  = 4'd0;
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hand_q      <= 4'd0;
      gap_q       <= 4'd0;
      deck_q      <= 6'(DECK_SIZE);
      game_q      <= 8'd0;
      in_valid1_q <= 1'b0;
      in_valid2_q <= 1'b0;
      user1_q     <= 4'd0;
      user2_q     <= 4'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hand_q      <= hand_d;
      gap_q       <= gap_d;
      deck_q      <= deck_d;
      game_q      <= game_d;
      in_valid1_q <= in_valid1_d;
      in_valid2_q <= in_valid2_d;
      user1_q     <= user1_d;
      user2_q     <= user2_d;
      err_q       <= err_d;
    end
  end

  assign in_valid1 = in_valid1_q;
  assign in_valid2 = in_valid2_q;
  assign user1     = user1_q;
  assign user2     = user2_q;
  assign err_card  = err_q;
  assign turn      = 2'(state_q);
  assign busy      = (state_q != IDLE);
  assign deck_left = deck_q;
  assign game_cnt  = game_q;

endmodule

// File: tb/tb_deal_sequencer.sv
// tb/tb_deal_sequencer.sv - table and scoreboard bench for deal_sequencer
module tb_deal_sequencer;

  logic       clk1 = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic       p1_req = 1'b0, p2_req = 1'b0;
  logic [3:0] p1_card = 4'd0, p2_card = 4'd0;
  logic       p1_ack, p2_ack, in_valid1, in_valid2, err_card, busy;
  logic [3:0] user1, user2;
  logic [1:0] turn;
  logic [5:0] deck_left;
  logic [7:0] game_cnt;

  logic       g_start = 1'b0, g_p1_req = 1'b0, g_p2_req = 1'b0;
  logic [3:0] g_p1_card = 4'd0, g_p2_card = 4'd0;
  logic       g_p1_ack, g_p2_ack, g_iv1, g_iv2, g_err, g_busy;
  logic [3:0] g_u1, g_u2;
  logic [1:0] g_turn;
  logic [5:0] g_deck;
  logic [7:0] g_game;

  always #5 clk1 = ~clk1;

  deal_sequencer dut (
    .clk1(clk1), .rst_n(rst_n), .start(start),
    .p1_req(p1_req), .p1_card(p1_card), .p1_ack(p1_ack),
    .p2_req(p2_req), .p2_card(p2_card), .p2_ack(p2_ack),
    .in_valid1(in_valid1), .user1(user1), .in_valid2(in_valid2), .user2(user2),
    .err_card(err_card), .turn(turn), .busy(busy),
    .deck_left(deck_left), .game_cnt(game_cnt)
  );

  deal_sequencer #(.GAP(1)) dut_g1 (
    .clk1(clk1), .rst_n(rst_n), .start(g_start),
    .p1_req(g_p1_req), .p1_card(g_p1_card), .p1_ack(g_p1_ack),
    .p2_req(g_p2_req), .p2_card(g_p2_card), .p2_ack(g_p2_ack),
    .in_valid1(g_iv1), .user1(g_u1), .in_valid2(g_iv2), .user2(g_u2),
    .err_card(g_err), .turn(g_turn), .busy(g_busy),
    .deck_left(g_deck), .game_cnt(g_game)
  );

  int tests = 0, fails = 0;

  typedef struct {
    int         kind;  // 1 = player 1 pulse, 2 = player 2 pulse, 3 = err_card
    logic [3:0] card;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    bit         st;
    int         pl;
    logic [3:0] card;
    bit         err;
    logic [5:0] deck;
    logic [1:0] turn;
  } vec_t;
  vec_t tbl[13];

  logic [3:0] g2p1 [5];
  logic [3:0] g2p2 [5];
  int mcnt [16];
  int mdeck;
  int cyc = 0;
  bit chk_space = 0;
  int last_pulse = -1;
  int turn_bad = 0, both_bad = 0;

  always @(posedge clk1) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  always @(negedge clk1) begin
    exp_t e;
    int gk;
    if (in_valid1 && in_valid2) both_bad++;
    if ((p1_ack && turn != 2'd1) || (p2_ack && turn != 2'd2)) turn_bad++;
    if (in_valid1 || in_valid2 || err_card) begin
      if (chk_space && (in_valid1 || in_valid2)) begin
        if (last_pulse >= 0) check("pulse_spacing", 64'(cyc - last_pulse), 64'd5);
        last_pulse = cyc;
      end
      gk = in_valid1 ? 1 : (in_valid2 ? 2 : 3);
      if (sb.size() == 0) begin
        check("sb_unexpected_output_kind", 64'(gk), 64'd0);
      end else begin
        e = sb.pop_front();
        check("sb_kind", 64'(gk), 64'(e.kind));
        if (gk == 1) check("sb_user1", 64'(user1), 64'(e.card));
        if (gk == 2) check("sb_user2", 64'(user2), 64'(e.card));
      end
    end
  end

  function automatic void model_reset();
    for (int r = 0; r < 16; r++) mcnt[r] = (r >= 1 && r <= 13) ? 4 : 0;
    mdeck = 52;
  endfunction

  function automatic void push_exp(input int kind, input logic [3:0] c);
    exp_t e;
    e.kind = kind;
    e.card = c;
    sb.push_back(e);
    if (kind != 3) begin
      mcnt[c]--;
      mdeck--;
    end
  endfunction

  function automatic logic [3:0] pick();
    for (int r = 1; r <= 13; r++) if (mcnt[r] > 0) return 4'(r);
    return 4'd0;
  endfunction

  task automatic start_game();
    start = 1'b1;
    @(posedge clk1); #1;
    start = 1'b0;
  endtask

  // Holds the request until acked; returns one time unit after the accepting edge.
  task automatic deal(input int pl, input logic [3:0] c, output bit ok);
    ok = 0;
    if (pl == 1) begin p1_req = 1'b1; p1_card = c; end
    else begin p2_req = 1'b1; p2_card = c; end
    for (int n = 0; n < 400; n++) begin
      @(negedge clk1);
      if ((pl == 1 && p1_ack) || (pl == 2 && p2_ack)) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk1); #1;
    if (pl == 1) p1_req = 1'b0;
    else p2_req = 1'b0;
    check("deal_ack_seen", 64'(ok), 64'd1);
  endtask

  task automatic deal_push(input int pl, input logic [3:0] c, input int kind);
    bit ok;
    deal(pl, c, ok);
    if (ok) push_exp(kind, c);
  endtask

  task automatic apply(input int lo, input int hi);
    bit ok;
    for (int i = lo; i <= hi; i++) begin
      if (tbl[i].st) start_game();
      deal(tbl[i].pl, tbl[i].card, ok);
      if (ok) push_exp(tbl[i].err ? 3 : tbl[i].pl, tbl[i].card);
      check($sformatf("row%0d_deck", i), 64'(deck_left), 64'(tbl[i].deck));
      check($sformatf("row%0d_turn", i), 64'(turn), 64'(tbl[i].turn));
    end
  endtask

  task automatic picked_game();
    start_game();
    for (int k = 0; k < 5; k++) deal_push(1, pick(), 1);
    check("picked_turn_p2", 64'(turn), 64'd2);
    for (int k = 0; k < 5; k++) deal_push(2, pick(), 2);
  endtask

  function automatic logic [63:0] out_vec();
    return 64'({in_valid1, user1, in_valid2, user2, err_card, turn, busy, deck_left, game_cnt});
  endfunction

  localparam logic [63:0] RESET_VEC = 64'({1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 2'd0, 1'b0, 6'd52, 8'd0});

  initial begin
    int g_n, g_pulses, g_last, g_both, g_spbad;
    tbl[0]  = '{1, 1, 4'd2,  0, 6'd51, 2'd1};
    tbl[1]  = '{0, 1, 4'd3,  0, 6'd50, 2'd1};
    tbl[2]  = '{0, 1, 4'd4,  0, 6'd49, 2'd1};
    tbl[3]  = '{0, 1, 4'd5,  0, 6'd48, 2'd1};
    tbl[4]  = '{0, 1, 4'd6,  0, 6'd47, 2'd2};
    tbl[5]  = '{0, 2, 4'd7,  0, 6'd46, 2'd2};
    tbl[6]  = '{0, 2, 4'd8,  0, 6'd45, 2'd2};
    tbl[7]  = '{0, 2, 4'd9,  0, 6'd44, 2'd2};
    tbl[8]  = '{0, 2, 4'd10, 0, 6'd43, 2'd2};
    tbl[9]  = '{0, 2, 4'd1,  0, 6'd42, 2'd0};
    tbl[10] = '{1, 1, 4'd0,  1, 6'd32, 2'd1};
    tbl[11] = '{0, 1, 4'd14, 1, 6'd32, 2'd1};
    tbl[12] = '{0, 1, 4'd7,  1, 6'd32, 2'd1};
    g2p1 = '{4'd7, 4'd7, 4'd7, 4'd11, 4'd12};
    g2p2 = '{4'd9, 4'd13, 4'd13, 4'd13, 4'd13};
    model_reset();

    #12;
    check("reset_outputs", out_vec(), RESET_VEC);
    @(posedge clk1); #1;
    rst_n = 1'b1;
    @(posedge clk1); #1;

    // Game 1: nominal with exact pulse spacing
    chk_space = 1; last_pulse = -1;
    apply(0, 9);
    chk_space = 0;
    check("g1_game_cnt", 64'(game_cnt), 64'd1);
    check("g1_busy", 64'(busy), 64'd0);

    // Game 2: player 2 requests card 9 during player 1's turn
    start_game();
    fork
      begin
        for (int k = 0; k < 5; k++) deal_push(1, g2p1[k], 1);
      end
      begin
        for (int k = 0; k < 5; k++) deal_push(2, g2p2[k], 2);
      end
    join
    check("g2_game_cnt", 64'(game_cnt), 64'd2);
    check("g2_deck", 64'(deck_left), 64'd32);

    // Game 3: illegal cards, rank 7 exhausted, then a normal remainder
    apply(10, 12);
    for (int k = 0; k < 5; k++) deal_push(1, pick(), 1);
    check("g3_turn_after_5_valid", 64'(turn), 64'd2);
    for (int k = 0; k < 5; k++) deal_push(2, pick(), 2);
    check("g3_game_cnt", 64'(game_cnt), 64'd3);

    picked_game();
    picked_game();
    check("g5_deck_at_reshuffle", 64'(deck_left), 64'd2);
    check("g5_game_cnt", 64'(game_cnt), 64'd5);
    @(posedge clk1); #1;
    check("deck_reloaded", 64'(deck_left), 64'd52);
    model_reset();

    // Game 6: rank 7 usable again, then reset after the third card
    start_game();
    deal_push(1, 4'd7, 1);
    deal_push(1, 4'd8, 1);
    deal_push(1, 4'd9, 1);
    check("g6_deck_before_reset", 64'(deck_left), 64'd49);
    rst_n = 1'b0;
    #1;
    check("midgame_reset_outputs", out_vec(), RESET_VEC);
    sb.delete();
    model_reset();
    @(posedge clk1); #1;
    rst_n = 1'b1;
    @(posedge clk1); #1;

    chk_space = 1; last_pulse = -1;
    apply(0, 9);
    chk_space = 0;
    check("post_reset_game_cnt", 64'(game_cnt), 64'd1);

    // GAP=1 instance with both requests held high for a whole game
    g_n = 0; g_pulses = 0; g_last = -1; g_both = 0; g_spbad = 0;
    g_start = 1'b1;
    @(posedge clk1); #1;
    g_start = 1'b0;
    for (int c = 0; c < 60 && g_pulses < 10; c++) begin
      g_p1_req = 1'b1; g_p2_req = 1'b1;
      g_p1_card = 4'(1 + g_n); g_p2_card = 4'(1 + g_n);
      @(negedge clk1);
      if (g_iv1 && g_iv2) g_both++;
      if (g_iv1 || g_iv2) begin
        if (g_last >= 0 && (c - g_last) != 2) g_spbad++;
        g_last = c;
        g_pulses++;
      end
      if (g_p1_ack || g_p2_ack) g_n++;
      @(posedge clk1); #1;
    end
    g_p1_req = 1'b0; g_p2_req = 1'b0;
    check("gap1_pulse_count", 64'(g_pulses), 64'd10);
    check("gap1_spacing_errors", 64'(g_spbad), 64'd0);
    check("gap1_simultaneous", 64'(g_both), 64'd0);
    check("gap1_game_cnt", 64'(g_game), 64'd1);
    check("gap1_deck", 64'(g_deck), 64'd42);
    check("gap1_user1_last", 64'(g_u1), 64'd5);
    check("gap1_user2_last", 64'(g_u2), 64'd10);

    repeat (3) @(posedge clk1);
    check("turn_order_violations", 64'(turn_bad), 64'd0);
    check("simultaneous_pulses", 64'(both_bad), 64'd0);
    check("sb_leftover", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
